bin_bcd_serial: RTL
===================

BIN_BCD_SERIAL -- requirements
Module: bin_bcd_serial

Interface
REQ-001 Parameter WIDTH, default 8, sets the binary input width; legal range 4..32.
REQ-002 Parameter DIGITS, default 3, sets the number of BCD output digits; elaboration SHALL fail unless 10^DIGITS > 2^WIDTH - 1.
REQ-003 Parameter SIGNED, default 0; 0 treats bin as unsigned, 1 treats it as two's complement.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to convert bin; sampled only in IDLE.
REQ-007 bin  input  WIDTH  binary operand; sampled in the cycle start is accepted.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse marking that bcd and neg are valid.
REQ-010 bcd  output  4*DIGITS  packed BCD result; digit 0 is bits [3:0] and is the least significant digit.
REQ-011 neg  output  1  sign of the last result; always 0 when SIGNED=0.

Function
REQ-012 The FSM SHALL have states IDLE and SHIFT, with a bit counter counting 0..WIDTH-1.
REQ-013 In IDLE with start=1 (acceptance cycle, call it cycle 0), the block SHALL:
  - load the magnitude of bin into the shift register;
  - clear the BCD scratch register;
  - capture the sign;
  - clear the counter;
  - go to SHIFT.
REQ-014 Magnitude: SIGNED=0 passes bin unchanged; SIGNED=1 with bin[WIDTH-1]=1 uses the WIDTH-bit unsigned value of -bin; the most negative input SHALL give magnitude 2^(WIDTH-1).
REQ-015 In each SHIFT cycle, every scratch digit >= 5 SHALL have 3 added; then {scratch, shift register} SHALL shift left by one bit, with the shift-register MSB entering scratch bit 0 (double-dabble).
REQ-016 After exactly WIDTH SHIFT cycles, the FSM SHALL return to IDLE, load bcd and neg from the final scratch and captured sign, and assert done for one cycle.
REQ-017 done SHALL be high in cycle WIDTH+1 after acceptance; busy SHALL be high in cycles 1..WIDTH and low when done is high.
REQ-018 start while busy=1 SHALL be ignored, with no effect on the ongoing conversion or its result.
REQ-019 start in the cycle done is high SHALL be accepted; back-to-back conversions SHALL achieve a throughput of one result per WIDTH+1 cycles.
REQ-020 bcd and neg SHALL hold their last value until the next done and SHALL NOT change at start.
REQ-021 A zero result SHALL report neg=0 regardless of SIGNED.
REQ-022 Every bcd digit SHALL always be in 0..9; unused high digits SHALL be 0.
REQ-023 No combinational path SHALL exist from inputs to outputs; all outputs are registered.

Reset
REQ-024 While rst_n=0, asynchronously and independent of clk: state=IDLE, counter=0, busy=0, done=0, bcd=0, neg=0, and all scratch and shift registers=0.
REQ-025 Reset asserted mid-conversion SHALL abort it with no done pulse; after release, the first start SHALL convert normally.
REQ-026 Release of rst_n is synchronised to clk externally; start SHALL be honoured from the first rising edge after release.

Verification
REQ-027 WIDTH=8, DIGITS=3, SIGNED=0: bin=255 with a 1-cycle start -> busy high in cycles 1..8, done in cycle 9, bcd=0x255, neg=0.
REQ-028 WIDTH=8, SIGNED=0: bin=0 -> bcd=0x000; then bin=99 started in the done cycle -> bcd=0x099 exactly 9 cycles later.
REQ-029 WIDTH=8, SIGNED=1: bin=0x80 -> bcd=0x128, neg=1; bin=0xFF -> bcd=0x001, neg=1; bin=0x7F -> bcd=0x127, neg=0.
REQ-030 WIDTH=4, DIGITS=2, SIGNED=0: sweep bin 0..15 -> bcd equals decimal value (13 -> 0x13, 9 -> 0x09), done 5 cycles after each start.
REQ-031 WIDTH=8: start bin=200, pulse start with bin=17 in cycle 4 -> a single done in cycle 9 with bcd=0x200.
REQ-032 WIDTH=8: start bin=150, assert rst_n=0 in cycle 5 -> outputs 0 immediately and no done; then start bin=42 -> bcd=0x042 after 9 cycles.
REQ-033 Random: 10k unsigned and signed operands at WIDTH=16, DIGITS=5 checked against a reference model for bcd, neg, and done timing.

Source files
------------

// File: rtl/bin_bcd_serial.sv
// rtl/bin_bcd_serial.sv - serial double-dabble binary to BCD converter
// One result bit per cycle; optional two's complement input with separate sign.
`timescale 1ns/1ps
module bin_bcd_serial #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                neg
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);

  function automatic bit digits_fit();
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < DIGITS; i++) p = p * 64'd10;
    return p > ((64'd1 << WIDTH) - 64'd1);
  endfunction

  localparam bit FITS = digits_fit();

  generate
    if (WIDTH < 4 || WIDTH > 32 || !FITS) begin : g_bad_params
      $error("bin_bcd_serial: illegal WIDTH/DIGITS combination");
    end
  endgenerate

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]   scr_q, scr_d;
  logic            sign_q, sign_d;
  logic            done_q, done_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            neg_q, neg_d;

  logic            in_neg;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   nxt_scr;
  logic            last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
    last = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
    done = done_q;
    bcd  = bcd_q;
    neg  = neg_q;
  end

  // Negating the most negative value wraps to itself, which read unsigned is 2^(WIDTH-1).
  always_comb begin
    in_neg = (SIGNED != 0) && bin[WIDTH-1];
    mag    = in_neg ? -bin : bin;
    for (int d = 0; d < DIGITS; d++) begin
      adj[4*d +: 4] = (scr_q[4*d +: 4] >= 4'd5) ? scr_q[4*d +: 4] + 4'd3 : scr_q[4*d +: 4];
    end
    nxt_scr = BW'({adj, shift_q[WIDTH-1]});
  end

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    scr_d   = scr_q;
    sign_d  = sign_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    if (state_q == IDLE && start) begin
      shift_d = mag;
      scr_d   = '0;
      sign_d  = in_neg;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      scr_d   = nxt_scr;
      shift_d = {shift_q[WIDTH-2:0], 1'b0};
      cnt_d   = last ? '0 : cnt_q + CW'(1);
      if (last) begin
        done_d = 1'b1;
        bcd_d  = nxt_scr;
        neg_d  = sign_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
      scr_q   <= '0;
      sign_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      scr_q   <= scr_d;
      sign_q  <= sign_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
    end
  end

endmodule
